// File: rtl/vga_sync_gen.sv
// Raster timing generator: h/v position counters with registered sync, blank and
// frame-tick outputs that are aligned with pix_x/pix_y in every cycle.
module vga_sync_gen #(
   parameter int H_VISIBLE       = 640,
   parameter int H_FRONT         = 16,
   parameter int H_SYNC          = 96,
   parameter int H_BACK          = 48,
   parameter int V_VISIBLE       = 480,
   parameter int V_FRONT         = 10,
   parameter int V_SYNC          = 2,
   parameter int V_BACK          = 33,
   parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pix_en,
   output logic       hsync,
   output logic       vsync,
   output logic       video_active,
   output logic [9:0] pix_x,
   output logic [9:0] pix_y,
   output logic [9:0] frame_counter,
   output logic       frame_tick
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   // 11-bit constants so a total of exactly 1024 does not alias to 0
   localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
   localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
   localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
   localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
   localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic        IDLE     = SYNC_ACTIVE_LOW;

   logic [9:0] h, v, h_nxt, v_nxt;
   logic       wrap_h, wrap_f;
   logic       hs_on, vs_on, act_nxt, tick_nxt;

   always_comb begin
      wrap_h = ({1'b0, h} == H_LAST);
      wrap_f = wrap_h && ({1'b0, v} == V_LAST);
      h_nxt  = wrap_h ? 10'd0 : h + 10'd1;
      v_nxt  = v;
      if (wrap_h)
         v_nxt = wrap_f ? 10'd0 : v + 10'd1;
   end

   // Output decodes look at the position being loaded, so the registered
   // flags describe the same pixel as the counters after the edge.
   always_comb begin
      hs_on    = ({1'b0, h_nxt} >= HS_START) && ({1'b0, h_nxt} < HS_END);
      vs_on    = ({1'b0, v_nxt} >= VS_START) && ({1'b0, v_nxt} < VS_END);
      act_nxt  = ({1'b0, h_nxt} < H_VIS) && ({1'b0, v_nxt} < V_VIS);
      tick_nxt = ({1'b0, h_nxt} == H_LAST) && ({1'b0, v_nxt} == V_LAST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h             <= '0;
         v             <= '0;
         hsync         <= IDLE;
         vsync         <= IDLE;
         video_active  <= 1'b1;
         frame_tick    <= 1'b0;
         frame_counter <= '0;
      end else if (pix_en) begin
         h            <= h_nxt;
         v            <= v_nxt;
         hsync        <= hs_on ^ IDLE;
         vsync        <= vs_on ^ IDLE;
         video_active <= act_nxt;
         frame_tick   <= tick_nxt;
         if (wrap_f)
            frame_counter <= frame_counter + 10'd1;
      end
   end

   assign pix_x = h;
   assign pix_y = v;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen on a shrunken raster (10x6) so that 1024
// frames fit in a short run; a second instance checks the active-high polarity.
module tb_vga_sync_gen;

   localparam int HV = 5, HF = 1, HS = 2, HB = 2;
   localparam int VV = 3, VF = 1, VS = 1, VB = 1;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;

   logic       clk = 1'b0, rst_n = 1'b0, pix_en = 1'b0;
   logic       a_hs, a_vs, a_act, a_tick;
   logic [9:0] a_x, a_y, a_fc;
   logic       b_hs, b_vs, b_act, b_tick;
   logic [9:0] b_x, b_y, b_fc;

   vga_sync_gen #(.H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                  .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
                  .SYNC_ACTIVE_LOW(1'b1)) dut_lo (
      .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .hsync(a_hs), .vsync(a_vs),
      .video_active(a_act), .pix_x(a_x), .pix_y(a_y), .frame_counter(a_fc),
      .frame_tick(a_tick));

   vga_sync_gen #(.H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                  .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
                  .SYNC_ACTIVE_LOW(1'b0)) dut_hi (
      .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .hsync(b_hs), .vsync(b_vs),
      .video_active(b_act), .pix_x(b_x), .pix_y(b_y), .frame_counter(b_fc),
      .frame_tick(b_tick));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic [9:0] fc;
      logic       act;
      logic       hs;
      logic       vs;
      logic       tick;
      logic       hs2;
      logic       vs2;
   } obs_t;

   obs_t       q[$];
   int         errors = 0, checks = 0;
   logic [9:0] mx = '0, my = '0, mfc = '0;
   event       async_chk;

   function automatic obs_t expect_now();
      obs_t e;
      logic hs_on, vs_on;
      hs_on  = (int'(mx) >= HV + HF) && (int'(mx) < HV + HF + HS);
      vs_on  = (int'(my) >= VV + VF) && (int'(my) < VV + VF + VS);
      e.x    = mx;
      e.y    = my;
      e.fc   = mfc;
      e.act  = (int'(mx) < HV) && (int'(my) < VV);
      e.hs   = ~hs_on;
      e.vs   = ~vs_on;
      e.tick = (int'(mx) == HT - 1) && (int'(my) == VT - 1);
      e.hs2  = hs_on;
      e.vs2  = vs_on;
      return e;
   endfunction

   task automatic step(input logic en, input logic rs);
      @(negedge clk);
      pix_en = en;
      rst_n  = rs;
      if (!rs) begin
         mx = '0; my = '0; mfc = '0;
      end else if (en) begin
         if (int'(mx) == HT - 1) begin
            mx = '0;
            if (int'(my) == VT - 1) begin
               my  = '0;
               mfc = mfc + 10'd1;
            end else my = my + 10'd1;
         end else mx = mx + 10'd1;
      end
      q.push_back(expect_now());
   endtask

   // reset asserted between edges; outputs must respond before the next edge
   task automatic async_reset();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      mx = '0; my = '0; mfc = '0;
      q.push_back(expect_now());
      -> async_chk;
   endtask

   initial begin : monitor
      obs_t e, g;
      forever begin
         @(posedge clk or async_chk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            g = '{x: a_x, y: a_y, fc: a_fc, act: a_act, hs: a_hs, vs: a_vs,
                  tick: a_tick, hs2: b_hs, vs2: b_vs};
            checks++;
            if (g !== e) begin
               errors++;
               $display("FAIL sb#%0d got x=%0d y=%0d fc=%0d act=%b hs=%b vs=%b tick=%b hs2=%b vs2=%b | want x=%0d y=%0d fc=%0d act=%b hs=%b vs=%b tick=%b hs2=%b vs2=%b",
                        checks, g.x, g.y, g.fc, g.act, g.hs, g.vs, g.tick, g.hs2, g.vs2,
                        e.x, e.y, e.fc, e.act, e.hs, e.vs, e.tick, e.hs2, e.vs2);
            end
         end
      end
   end

   initial begin : watchdog
      #1500000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin : stim
      repeat (3) step(1'b1, 1'b0);
      step(1'b1, 1'b1);                     // first enabled edge -> (1,0)
      repeat (13) step(1'b1, 1'b1);         // mid-line on line 1
      async_reset();
      step(1'b1, 1'b0);
      step(1'b0, 1'b1);                     // released but disabled: hold (0,0)
      step(1'b1, 1'b1);
      repeat (2 * HT * VT + 5) step(1'b1, 1'b1);
      repeat (2 * HT) begin                 // alternating enable stretches pulses
         step(1'b1, 1'b1);
         step(1'b0, 1'b1);
      end
      repeat (200) step(1'($urandom_range(1, 0)), 1'b1);
      while (mfc != 10'd0) step(1'b1, 1'b1); // frame counter rolls 1023 -> 0
      repeat (HT + 3) step(1'b1, 1'b1);
      repeat (4) @(posedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
